// File: rtl/bus_xfer_if.sv
// bus_xfer_if: request handshake plus bus enable/load lines of bus_xfer_ctrl.
// BUS_XFER_CTRL_STATS_EN adds the xfer_count/err_count statistics lines.
interface bus_xfer_if #(
    parameter int NSRC = 4,
    parameter int NDST = 4
);
    localparam int SW = $clog2(NSRC);
    localparam int DW = $clog2(NDST);
    logic            req_valid;
    logic            req_ready;
    logic [SW-1:0]   req_src;
    logic [DW-1:0]   req_dst;
    logic [NSRC-1:0] src_en;
    logic [NDST-1:0] dst_load;
    logic            busy;
    logic            done;
    logic            err;
`ifdef BUS_XFER_CTRL_STATS_EN
    logic [15:0]     xfer_count;
    logic [7:0]      err_count;
    modport master (output req_valid, req_src, req_dst,
                    input req_ready, src_en, dst_load, busy, done, err, xfer_count, err_count);
    modport slave (input req_valid, req_src, req_dst,
                   output req_ready, src_en, dst_load, busy, done, err, xfer_count, err_count);
`else
    modport master (output req_valid, req_src, req_dst,
                    input req_ready, src_en, dst_load, busy, done, err);
    modport slave (input req_valid, req_src, req_dst,
                   output req_ready, src_en, dst_load, busy, done, err);
`endif
endinterface

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: break-before-make sequencer for the data-bus tri-state buffers.
// BUS_XFER_CTRL_STATS_EN adds transfer/reject counters on the interface.
module bus_xfer_ctrl #(
    parameter int NSRC        = 4,
    parameter int NDST        = 4,
    parameter int DEAD_CYCLES = 1
) (
    input logic       clk,
    input logic       reset,
    bus_xfer_if.slave bus
);
    localparam int SW = $clog2(NSRC);
    localparam int DW = $clog2(NDST);
    localparam int CW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [SW:0] SRC_LIM = NSRC[SW:0];
    localparam logic [DW:0] DST_LIM = NDST[DW:0];
    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, RELEASE} state_t;
    state_t          state, state_n;
    logic [SW-1:0]   src_q, src_n;
    logic [DW-1:0]   dst_q, dst_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NSRC-1:0] src_en_n;
    logic [NDST-1:0] dst_load_n;
    logic            done_n, err_n, accept, legal;
    assign accept = bus.req_valid && bus.req_ready;
    assign legal  = ({1'b0, bus.req_src} < SRC_LIM) && ({1'b0, bus.req_dst} < DST_LIM);
    always_comb begin
        state_n    = state;
        src_n      = src_q;
        dst_n      = dst_q;
        cnt_n      = cnt;
        src_en_n   = '0;
        dst_load_n = '0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (legal) begin
                    state_n  = DRIVE;
                    src_n    = bus.req_src;
                    dst_n    = bus.req_dst;
                    src_en_n = NSRC'(1) << bus.req_src;
                end else
                    err_n = 1'b1;
            end
            DRIVE: begin
                state_n    = LOAD;
                src_en_n   = NSRC'(1) << src_q;
                dst_load_n = NDST'(1) << dst_q;
            end
            LOAD: begin
                state_n = RELEASE;
                done_n  = 1'b1;
                cnt_n   = CW'(DEAD_CYCLES - 1);
            end
            RELEASE: begin
                state_n = cnt == '0 ? IDLE : RELEASE;
                cnt_n   = cnt == '0 ? cnt : cnt - CW'(1);
            end
            default: state_n = IDLE;
        endcase
    end
    // Output flops clear on the reset edge itself so the buffers release the bus at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            cnt           <= '0;
            bus.src_en    <= '0;
            bus.dst_load  <= '0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
        end else begin
            state         <= state_n;
            src_q         <= src_n;
            dst_q         <= dst_n;
            cnt           <= cnt_n;
            bus.src_en    <= src_en_n;
            bus.dst_load  <= dst_load_n;
            bus.done      <= done_n;
            bus.err       <= err_n;
            bus.busy      <= state_n != IDLE;
            bus.req_ready <= state_n == IDLE;
        end
    end
`ifdef BUS_XFER_CTRL_STATS_EN
    logic [15:0] xfer_cnt;
    logic [7:0]  err_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (done_n)
                xfer_cnt <= xfer_cnt + 16'd1;
            if (err_n && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end
    assign bus.xfer_count = xfer_cnt;
    assign bus.err_count  = err_cnt;
`endif
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: vector tables, async-reset sequence and a randomized timeline model
// over two instances (4x4 with one dead cycle, 3x3 with three dead cycles).
module tb_bus_xfer_ctrl;
    localparam int DA = 1;
    localparam int DB = 3;
    typedef struct packed {
        logic [3:0] src_en;
        logic [3:0] dst_load;
        logic       done, err, busy, ready;
    } out_t;
    typedef struct packed {
        logic       v;
        logic [1:0] s, d;
        out_t       e;
    } vec_t;
    localparam out_t IDLE_O = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_xfer_if #(.NSRC(4), .NDST(4)) ifa ();
    bus_xfer_if #(.NSRC(3), .NDST(3)) ifb ();
    bus_xfer_ctrl #(.NSRC(4), .NDST(4), .DEAD_CYCLES(DA)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    bus_xfer_ctrl #(.NSRC(3), .NDST(3), .DEAD_CYCLES(DB)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    logic       v[2];
    logic [1:0] s[2], d[2];
    logic [3:0] o_src[2], o_dl[2];
    logic       o_done[2], o_err[2], o_busy[2], o_rdy[2];
    assign ifa.req_valid = v[0];
    assign ifa.req_src   = s[0];
    assign ifa.req_dst   = d[0];
    assign ifb.req_valid = v[1];
    assign ifb.req_src   = s[1];
    assign ifb.req_dst   = d[1];
    assign o_src[0]  = ifa.src_en;
    assign o_src[1]  = {1'b0, ifb.src_en};
    assign o_dl[0]   = ifa.dst_load;
    assign o_dl[1]   = {1'b0, ifb.dst_load};
    assign o_done[0] = ifa.done;
    assign o_done[1] = ifb.done;
    assign o_err[0]  = ifa.err;
    assign o_err[1]  = ifb.err;
    assign o_busy[0] = ifa.busy;
    assign o_busy[1] = ifb.busy;
    assign o_rdy[0]  = ifa.req_ready;
    assign o_rdy[1]  = ifb.req_ready;

    int compared = 0;
    int mismatched = 0;

    function automatic out_t got(input int k);
        return '{o_src[k], o_dl[k], o_done[k], o_err[k], o_busy[k], o_rdy[k]};
    endfunction

    function automatic vec_t row(input logic v_, input logic [1:0] s_, d_, input logic [3:0] se, dl,
                                 input logic dn, er, bz, rd);
        return '{v_, s_, d_, '{se, dl, dn, er, bz, rd}};
    endfunction

    task automatic check(input string name, input int k, input out_t e);
        out_t g;
        g = got(k);
        compared++;
        if (g !== e) begin
            mismatched++;
            $display("FAIL %s dut%0d @%0t: got src_en=%b dst_load=%b done=%b err=%b busy=%b ready=%b, expected src_en=%b dst_load=%b done=%b err=%b busy=%b ready=%b",
                     name, k, $time, g.src_en, g.dst_load, g.done, g.err, g.busy, g.ready,
                     e.src_en, e.dst_load, e.done, e.err, e.busy, e.ready);
        end
    endtask

    task automatic check_val(input string name, input int g, input int e);
        compared++;
        if (g != e) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, g, e);
        end
    endtask

    task automatic run_table(input int k, input vec_t t[$], input string tag);
        foreach (t[i]) begin
            v[k] = t[i].v;
            s[k] = t[i].s;
            d[k] = t[i].d;
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), k, t[i].e);
        end
        v[k] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                compared++;
                if (!$onehot0(o_src[k]) || !$onehot0(o_dl[k])) begin
                    mismatched++;
                    $display("FAIL onehot0 dut%0d @%0t: src_en=%b dst_load=%b", k, $time, o_src[k], o_dl[k]);
                end
            end
        end
    end

    vec_t ta[$], tb_rows[$];
    int last_acc[2], last_err[2], free_at[2], ms[2], md[2];

    function automatic int nlim(input int k);
        return k == 0 ? 4 : 3;
    endfunction

    function automatic int dead(input int k);
        return k == 0 ? DA : DB;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            v[k] = 1'b0;
            s[k] = 2'd0;
            d[k] = 2'd0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_idle", 0, IDLE_O);
            check("reset_idle", 1, IDLE_O);
        end
        // Single 1->2 transfer, then (0->3) and (2->0) with valid held high.
        ta = '{row(1, 1, 2, 4'b0010, 4'b0000, 0, 0, 1, 0), row(0, 0, 0, 4'b0010, 4'b0100, 0, 0, 1, 0),
               row(0, 0, 0, 4'b0000, 4'b0000, 1, 0, 1, 0), row(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1),
               row(1, 0, 3, 4'b0001, 4'b0000, 0, 0, 1, 0), row(1, 2, 0, 4'b0001, 4'b1000, 0, 0, 1, 0),
               row(1, 2, 0, 4'b0000, 4'b0000, 1, 0, 1, 0), row(1, 2, 0, 4'b0000, 4'b0000, 0, 0, 0, 1),
               row(1, 2, 0, 4'b0100, 4'b0000, 0, 0, 1, 0), row(0, 0, 0, 4'b0100, 4'b0001, 0, 0, 1, 0),
               row(0, 0, 0, 4'b0000, 4'b0000, 1, 0, 1, 0), row(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1)};
        // Illegal src/dst on the 3x3 instance and three dead cycles between queued transfers.
        tb_rows = '{row(1, 3, 0, 4'b0000, 4'b0000, 0, 1, 0, 1), row(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1),
                    row(1, 2, 1, 4'b0100, 4'b0000, 0, 0, 1, 0), row(1, 1, 2, 4'b0100, 4'b0010, 0, 0, 1, 0),
                    row(1, 1, 2, 4'b0000, 4'b0000, 1, 0, 1, 0), row(1, 1, 2, 4'b0000, 4'b0000, 0, 0, 1, 0),
                    row(1, 1, 2, 4'b0000, 4'b0000, 0, 0, 1, 0), row(1, 1, 2, 4'b0000, 4'b0000, 0, 0, 0, 1),
                    row(1, 1, 2, 4'b0010, 4'b0000, 0, 0, 1, 0), row(0, 0, 0, 4'b0010, 4'b0100, 0, 0, 1, 0),
                    row(0, 0, 0, 4'b0000, 4'b0000, 1, 0, 1, 0), row(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0),
                    row(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0), row(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1),
                    row(1, 0, 3, 4'b0000, 4'b0000, 0, 1, 0, 1), row(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1)};
        run_table(0, ta, "tblA");
        run_table(1, tb_rows, "tblB");
`ifdef BUS_XFER_CTRL_STATS_EN
        check_val("xfer_count_a", int'(ifa.xfer_count), 3);
        check_val("err_count_a", int'(ifa.err_count), 0);
        check_val("xfer_count_b", int'(ifb.xfer_count), 2);
        check_val("err_count_b", int'(ifb.err_count), 2);
`endif
        // Reset pulsed between edges while dut_a is driving the bus.
        v[0] = 1'b1;
        s[0] = 2'd3;
        d[0] = 2'd1;
        @(posedge clk);
        #1 v[0] = 1'b0;
        #2 check("mid_drive", 0, '{4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0});
        reset = 1'b1;
        #1 check("async_reset", 0, IDLE_O);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset", 0, IDLE_O);
        end
`ifdef BUS_XFER_CTRL_STATS_EN
        force dut_a.xfer_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_a.xfer_cnt;
        v[0] = 1'b1;
        s[0] = 2'd2;
        d[0] = 2'd2;
        @(negedge clk);
        v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check_val("xfer_count_wrap", int'(ifa.xfer_count), 0);
`endif
        // Random traffic against a timeline model keyed on the last accepted request.
        for (int k = 0; k < 2; k++) begin
            last_acc[k] = -100;
            last_err[k] = -100;
            free_at[k]  = -100;
            ms[k]       = 0;
            md[k]       = 0;
        end
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < 2; k++) begin
                v[k] = 1'($urandom_range(0, 1));
                s[k] = 2'($urandom_range(0, 3));
                d[k] = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (v[k] && t - 1 >= free_at[k]) begin
                    if (int'(s[k]) < nlim(k) && int'(d[k]) < nlim(k)) begin
                        last_acc[k] = t;
                        ms[k]       = int'(s[k]);
                        md[k]       = int'(d[k]);
                        free_at[k]  = t + 2 + dead(k);
                    end else
                        last_err[k] = t;
                end
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int   kk;
                out_t e;
                kk         = t - last_acc[k];
                e.src_en   = (kk == 0 || kk == 1) ? 4'(1 << ms[k]) : 4'd0;
                e.dst_load = kk == 1 ? 4'(1 << md[k]) : 4'd0;
                e.done     = kk == 2;
                e.err      = t == last_err[k];
                e.busy     = kk >= 0 && kk < 2 + dead(k);
                e.ready    = t >= free_at[k];
                check("random", k, e);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
